// File: rtl/input_port_fifo_if.sv
// rtl/input_port_fifo_if.sv - producer/processor-side signal bundle for input_port_fifo
interface input_port_fifo_if #(
   parameter int ADDR_W = 3
);
   logic [7:0]      wr_data;
   logic            wr_en;
   logic            full;
   logic            empty;
   logic [ADDR_W:0] count;
   logic [7:0]      in;
   logic            inDataReady;
   logic            inACK;
   logic [7:0]      overflow_cnt;

   modport master (
      output wr_data, wr_en, inACK,
      input  full, empty, count, in, inDataReady, overflow_cnt
   );

   modport slave (
      input  wr_data, wr_en, inACK,
      output full, empty, count, in, inDataReady, overflow_cnt
   );
endinterface

// File: rtl/input_port_fifo.sv
// rtl/input_port_fifo.sv - byte FIFO feeding the Processor's four-phase input handshake
// Optional dropped-write counter enabled by `define INPUT_PORT_OVERFLOW_CNT_EN.
module input_port_fifo #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input logic                clk,
   input logic                reset,
   input_port_fifo_if.slave   bus
);
   typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_WAIT_LOW} state_t;

   localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

   state_t            r_state;
   logic [7:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_full;
   logic              r_empty;
   logic [7:0]        r_in;
   logic              r_rdy;

   logic              w_pop;
   logic              w_wr_acc;
   logic [ADDR_W:0]   w_count_nxt;

   // The pop is the ACK edge of PRESENT; a write into a full FIFO is legal on that same edge.
   assign w_pop    = (r_state == S_PRESENT) && bus.inACK;
   assign w_wr_acc = bus.wr_en && (!r_full || w_pop);

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr_acc && !w_pop)
         w_count_nxt = r_count + (ADDR_W+1)'(1);
      else if (!w_wr_acc && w_pop)
         w_count_nxt = r_count - (ADDR_W+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (w_wr_acc)
         r_mem[r_wr_ptr] <= bus.wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_wr_acc)
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == C_DEPTH);
         r_empty <= (w_count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_in    <= 8'h00;
         r_rdy   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!r_empty && !bus.inACK) begin
                  r_state <= S_PRESENT;
                  r_in    <= r_mem[r_rd_ptr];
                  r_rdy   <= 1'b1;
               end
            end
            S_PRESENT: begin
               if (bus.inACK) begin
                  r_state <= S_WAIT_LOW;
                  r_rdy   <= 1'b0;
               end
            end
            S_WAIT_LOW: begin
               if (!bus.inACK)
                  r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_rdy   <= 1'b0;
            end
         endcase
      end
   end

`ifdef INPUT_PORT_OVERFLOW_CNT_EN
   logic [7:0] r_overflow_cnt;
   logic       w_drop;

   assign w_drop = bus.wr_en && r_full && !w_pop;

   always_ff @(posedge clk) begin
      if (reset)
         r_overflow_cnt <= 8'h00;
      else if (w_drop && (r_overflow_cnt != 8'hFF))
         r_overflow_cnt <= r_overflow_cnt + 8'h01;
   end

   assign bus.overflow_cnt = r_overflow_cnt;
`else
   assign bus.overflow_cnt = 8'h00;
`endif

   assign bus.full        = r_full;
   assign bus.empty       = r_empty;
   assign bus.count       = r_count;
   assign bus.in          = r_in;
   assign bus.inDataReady = r_rdy;
endmodule

// File: doc/input_port_fifo.md
Name: input_port_fifo

Overview:
- Buffered input channel that sits directly upstream of the Processor's input port.
- Accepts bytes from an external producer (switch bank, serial receiver, bench driver) into a small FIFO.
- Presents them one at a time on the Processor's in[7:0] / inDataReady / inACK four-phase handshake.
- Decouples producer timing from the Processor's state machine, so bytes arriving while the Processor is busy are not lost.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, 2..256.
- ADDR_W, 3, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_data  input  8  byte from external producer.
- wr_en  input  1  write strobe; wr_data captured on the edge where wr_en=1 and the write is accepted.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries (the presented byte is not counted once popped).
- count  output  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- in  output  8  byte to Processor input; connects to Processor.in.
- inDataReady  output  1  byte on `in` is valid; connects to Processor.inDataReady.
- inACK  input  1  Processor has latched `in`; from Processor.inACK.
- overflow_cnt  output  8  saturating count of dropped writes (see Optional Feature).

Behaviour:
- Reset: one clock, synchronous, active-high. On a reset edge:
  - rd/wr pointers=0, count=0, full=0, empty=1;
  - in=8'h00, inDataReady=0, overflow_cnt=0, FSM=IDLE.
  - Reset mid-handshake discards the presented byte and all FIFO contents; inDataReady drops on that edge regardless of inACK.
- FIFO:
  - Circular buffer; pointers are ADDR_W bits and wrap DEPTH-1 -> 0.
  - full/empty/count are registered and derived from count.
  - Write accepted iff wr_en=1 and (count<DEPTH or a pop occurs on the same edge).
  - Write with wr_en=1 while full and no pop: byte dropped; pointers and count unchanged.
  - Simultaneous accepted write and pop: count unchanged, both pointers advance.
- FSM, three states:
  - IDLE: if !empty and inACK=0 -> PRESENT. On that edge, in <= FIFO[rd_ptr] and inDataReady <= 1. No pop yet.
  - PRESENT: hold in and inDataReady=1. When inACK sampled 1 -> WAIT_LOW. On that edge inDataReady <= 0, rd_ptr advances, count decrements (the pop).
  - WAIT_LOW: inDataReady=0, in holds last byte. When inACK sampled 0 -> IDLE.
- Latency: a byte written into an empty FIFO on edge N (FSM in IDLE, inACK=0) drives inDataReady=1 after edge N+1.
- Minimum handshake period is 4 cycles per byte (PRESENT, WAIT_LOW, IDLE, PRESENT) when inACK responds in one cycle.
- inACK=1 while in IDLE is ignored; the FSM waits in IDLE until it falls.
- The `in` value is stable for the whole time inDataReady=1.
- The `in` value changes only on the IDLE->PRESENT edge or on reset.

Optional Feature:
- Macro: INPUT_PORT_OVERFLOW_CNT_EN.
- Defined: overflow_cnt increments by 1 on each edge where a write is dropped (wr_en=1, full, no pop). It saturates at 8'hFF and clears only on reset.
- Not defined: overflow_cnt is tied to 8'h00 and no counter register is built. Dropping behaviour is otherwise identical.

Test Plan:
- Reset, then write 8'hA5 with inACK held 0 -> count=1 after the write edge; inDataReady=1 and in=8'hA5 one edge later; count stays 1 until the ACK.
- Raise inACK one cycle after inDataReady -> inDataReady=0 and count=0 on the next edge. Drop inACK -> FSM returns to IDLE; empty=1; in holds 8'hA5.
- Burst-write 8'h01..8'h08 (DEPTH=8) with no ACKs, then a 9th write 8'h09 -> full=1 and count=8, 8'h09 dropped. With the macro: overflow_cnt=1; without: 0. Draining via handshakes yields 01..08 in order, then empty=1.
- While full and in PRESENT, assert wr_en=1 (data 8'hCC) on the same edge inACK is sampled 1 -> write accepted, count stays 8, 8'hCC emerges ninth.
- Hold inACK=1 from reset, write 8'h33 -> inDataReady stays 0. Release inACK -> inDataReady=1 with in=8'h33 one edge later.
- Assert reset while inDataReady=1 and count=3 -> after that edge inDataReady=0, in=8'h00, count=0, empty=1, overflow_cnt=0.
